pipe_hazard_ctrl: RTL and testbench

//  Sequencing controller for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB).
//  - Generates stall/flush enables for the PC and the four pipeline registers.
//  - Selects EX-stage operand forwarding.
//  - Runs a data-memory wait FSM with a timeout, plus saturating stall/flush performance counters.
//  - Sits beside the decoder: consumes per-stage rd/rs/RegWrite/MemRead fields and the EX redirect.

---
 rtl/pipe_hazard_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard sequencing for a 5-stage RISC-V pipeline: stall/flush steering, EX operand
// forwarding, a data-memory wait FSM with timeout, and saturating stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             ex_redirect,
    input  logic [4:0]       mem_rd,
    input  logic             mem_regwrite,
    input  logic             mem_req,
    input  logic             dmem_ready,
    input  logic [4:0]       wb_rd,
    input  logic             wb_regwrite,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_stall,
    output logic             idex_flush,
    output logic             exmem_stall,
    output logic             memwb_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             bus_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int WC_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t           state_r;
    logic [WC_W-1:0]  wait_cnt_r;
    logic             bus_err_r;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;
    logic             mem_stall_s;
    logic             load_use_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    // MEM result is younger than WB, so it wins; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] m_rd, input logic m_we,
                                           input logic [4:0] w_rd, input logic w_we);
        if (m_we && (m_rd != 5'd0) && (m_rd == rs)) begin
            return 2'b10;
        end else if (w_we && (w_rd != 5'd0) && (w_rd == rs)) begin
            return 2'b01;
        end else begin
            return 2'b00;
        end
    endfunction

    // Hazard detection from current FSM state and stage fields.
    always_comb begin
        mem_stall_s = (state_r == ST_ERR)
                    | ((state_r == ST_WAIT) & ~dmem_ready)
                    | ((state_r == ST_RUN) & mem_req & ~dmem_ready);
        load_use_s  = ex_memread & (ex_rd != 5'd0)
                    & ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    end

    // Prioritised steering: mem stall > redirect > load-use; all quiet while in reset.
    always_comb begin
        pc_stall     = 1'b0;
        ifid_stall   = 1'b0;
        ifid_flush   = 1'b0;
        idex_stall   = 1'b0;
        idex_flush   = 1'b0;
        exmem_stall  = 1'b0;
        memwb_bubble = 1'b0;
        if (rst) begin
            pc_stall = 1'b0;
        end else if (mem_stall_s) begin
            pc_stall     = 1'b1;
            ifid_stall   = 1'b1;
            idex_stall   = 1'b1;
            exmem_stall  = 1'b1;
            memwb_bubble = 1'b1;
        end else if (ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use_s) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
        end else begin
            pc_stall = 1'b0;
        end
    end

    // EX operand forwarding selects.
    always_comb begin
        fwd_a = fwd_sel(ex_rs1, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
        fwd_b = fwd_sel(ex_rs2, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
    end

    // Data-memory wait FSM; ERR is terminal until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_RUN;
            wait_cnt_r <= '0;
            bus_err_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    wait_cnt_r <= '0;
                    if (mem_req && !dmem_ready) begin
                        state_r <= ST_WAIT;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_WAIT: begin
                    if (dmem_ready) begin
                        state_r    <= ST_RUN;
                        wait_cnt_r <= '0;
                    end else if (wait_cnt_r == WAIT_LAST) begin
                        state_r    <= ST_ERR;
                        wait_cnt_r <= '0;
                        bus_err_r  <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WC_W'(1);
                    end
                end
                ST_ERR: begin
                    bus_err_r <= 1'b1;
                end
                default: begin
                    // Unreachable encoding: freeze the pipeline rather than resume blindly.
                    state_r    <= ST_ERR;
                    wait_cnt_r <= '0;
                    bus_err_r  <= 1'b1;
                end
            endcase
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= '0;
            flush_cnt_r <= '0;
        end else begin
            if (pc_stall) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end
            if (ifid_flush) begin
                flush_cnt_r <= sat_inc(flush_cnt_r);
            end
        end
    end

    assign bus_err      = bus_err_r;
    assign stall_cycles = stall_cnt_r;
    assign flush_events = flush_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl against a rule-level reference model
// (small timeout and narrow counters so error entry and saturation are reached).
module tb_pipe_hazard_ctrl;

    localparam int MT = 4;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic id_use_rs1, id_use_rs2, ex_memread, ex_redirect;
    logic mem_regwrite, mem_req, dmem_ready, wb_regwrite;
    logic pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_bubble;
    logic [1:0] fwd_a, fwd_b;
    logic bus_err;
    logic [CW-1:0] stall_cycles, flush_events;

    int vec_n = 0;
    int err_n = 0;
    bit m_err, m_wait;
    int m_waited, m_stall, m_flush;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_memread(ex_memread),
        .ex_redirect(ex_redirect), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .mem_req(mem_req), .dmem_ready(dmem_ready), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
        .idex_stall(idex_stall), .idex_flush(idex_flush), .exmem_stall(exmem_stall),
        .memwb_bubble(memwb_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b), .bus_err(bus_err),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_n++;
        if (got !== exp) begin
            err_n++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (mem_regwrite && mem_rd != 0 && mem_rd == rs) return 2'b10;
        if (wb_regwrite && wb_rd != 0 && wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [6:0] ctl_vec();
        return {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_bubble};
    endfunction

    task automatic clear_inputs();
        {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
        {id_use_rs1, id_use_rs2, ex_memread, ex_redirect} = '0;
        {mem_regwrite, mem_req, dmem_ready, wb_regwrite} = '0;
    endtask

    // Called at posedge+1: checks combinational outputs, advances model, checks registers.
    task automatic cycle();
        logic mstall, lu;
        logic [6:0] exp_v;
        #2;
        mstall = m_err || (m_wait && !dmem_ready) || (!m_wait && mem_req && !dmem_ready);
        lu = ex_memread && ex_rd != 0 &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        if (mstall)           exp_v = 7'b1101011;
        else if (ex_redirect) exp_v = 7'b0010100;
        else if (lu)          exp_v = 7'b1100100;
        else                  exp_v = 7'b0000000;
        check_val("ctl", 32'(ctl_vec()), 32'(exp_v));
        check_val("fwd_a", 32'(fwd_a), 32'(ref_fwd(ex_rs1)));
        check_val("fwd_b", 32'(fwd_b), 32'(ref_fwd(ex_rs2)));
        if (exp_v[6] && m_stall < CMAX) m_stall++;
        if (exp_v[4] && m_flush < CMAX) m_flush++;
        if (m_err) begin
            m_err = 1'b1;
        end else if (m_wait) begin
            if (dmem_ready) m_wait = 1'b0;
            else if (m_waited == MT - 1) begin m_err = 1'b1; m_wait = 1'b0; end
            else m_waited++;
        end else if (mem_req && !dmem_ready) begin
            m_wait = 1'b1;
            m_waited = 0;
        end
        @(posedge clk);
        #1;
        check_val("bus_err", 32'(bus_err), 32'(m_err));
        check_val("stall_cycles", 32'(stall_cycles), 32'(m_stall));
        check_val("flush_events", 32'(flush_events), 32'(m_flush));
    endtask

    // Asynchronous reset: everything must drop immediately, mid-cycle.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_val("rst_ctl", 32'(ctl_vec()), 32'd0);
        check_val("rst_bus_err", 32'(bus_err), 32'd0);
        check_val("rst_stall_cnt", 32'(stall_cycles), 32'd0);
        check_val("rst_flush_cnt", 32'(flush_events), 32'd0);
        m_err = 1'b0; m_wait = 1'b0; m_waited = 0; m_stall = 0; m_flush = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;
        do_reset();

        // load-use: lw x5 in EX, ID reads x5
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        cycle();
        clear_inputs();
        cycle();
        // redirect beats a concurrent load-use
        ex_memread = 1'b1; ex_rd = 5'd6; id_rs2 = 5'd6; id_use_rs2 = 1'b1; ex_redirect = 1'b1;
        cycle();
        clear_inputs();
        // three wait cycles then ready, with a redirect pending behind the stall
        mem_req = 1'b1; ex_redirect = 1'b1;
        repeat (3) cycle();
        dmem_ready = 1'b1;
        cycle();
        clear_inputs();
        cycle();
        // forwarding priority
        mem_rd = 5'd7; wb_rd = 5'd7; ex_rs1 = 5'd7; ex_rs2 = 5'd7;
        mem_regwrite = 1'b1; wb_regwrite = 1'b1;
        cycle();
        mem_rd = 5'd0;
        cycle();
        wb_rd = 5'd0;
        cycle();
        clear_inputs();
        // timeout into ERR, held long enough to saturate the stall counter
        mem_req = 1'b1;
        repeat (20) cycle();
        do_reset();
        clear_inputs();

        for (int n = 0; n < 600; n++) begin
            id_rs1 = 5'($urandom_range(0, 3));
            id_rs2 = 5'($urandom_range(0, 3));
            ex_rs1 = 5'($urandom_range(0, 3));
            ex_rs2 = 5'($urandom_range(0, 3));
            ex_rd  = 5'($urandom_range(0, 3));
            mem_rd = 5'($urandom_range(0, 3));
            wb_rd  = 5'($urandom_range(0, 3));
            id_use_rs1   = 1'($urandom_range(0, 1));
            id_use_rs2   = 1'($urandom_range(0, 1));
            ex_memread   = 1'($urandom_range(0, 1));
            ex_redirect  = ($urandom_range(0, 4) == 0);
            mem_regwrite = 1'($urandom_range(0, 1));
            wb_regwrite  = 1'($urandom_range(0, 1));
            mem_req      = ($urandom_range(0, 3) == 0);
            dmem_ready   = ($urandom_range(0, 2) != 0);
            if (m_err && $urandom_range(0, 3) == 0) begin
                do_reset();
            end else begin
                cycle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
        $finish;
    end

endmodule
